// File: rtl/reg32_readback.sv
// -----------------------------------------------------------------------------
// reg32_readback
//
// Read-side companion to a bank of NREGS 32-bit control registers. A single
// outstanding read is serviced over a req/valid/ack handshake through a
// three-state FSM (IDLE -> SEL -> RESP -> IDLE). No write path.
//
// Optional feature (macro READBACK_SNAPSHOT_EN):
//   A shadow bank captures all of reg_in on any edge with snap=1, and reads
//   select from the shadow bank so multi-register reads are coherent.
//   Without the macro, reads select directly from reg_in and snap is unused.
//
// Ports:
//   clk       in   single clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   reg_in    in   flattened register values, reg i at [32*i+31:32*i]
//   snap      in   snapshot strobe (READBACK_SNAPSHOT_EN only)
//   rd_req    in   read request, sampled while rd_busy=0
//   rd_addr   in   register index, sampled with rd_req
//   rd_ack    in   consumer took rd_data, sampled in RESP only
//   rd_busy   out  read in flight; requests are dropped
//   rd_valid  out  rd_data / rd_err valid
//   rd_data   out  returned register value
//   rd_err    out  requested index was >= NREGS
// -----------------------------------------------------------------------------
module reg32_readback #(
    parameter int NREGS = 8,
    parameter int AW    = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [32*NREGS-1:0]   reg_in,
    input  logic                  snap,
    input  logic                  rd_req,
    input  logic [AW-1:0]         rd_addr,
    input  logic                  rd_ack,
    output logic                  rd_busy,
    output logic                  rd_valid,
    output logic [31:0]           rd_data,
    output logic                  rd_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEL  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [31:0] NREGS_U = 32'(NREGS);

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   rd_data_q, rd_data_d;
    logic          rd_err_q, rd_err_d;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_busy_q, rd_busy_d;

    logic [31:0]   src_s [NREGS];
    logic [31:0]   addr_ext_s;
    logic [31:0]   sel_data_s;
    logic          sel_hit_s;

`ifdef READBACK_SNAPSHOT_EN
    logic [31:0]   shadow_q [NREGS];
    logic [31:0]   shadow_d [NREGS];

    // Shadow next-state: capture the whole bank on snap, otherwise hold.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            if (snap) begin
                shadow_d[i] = reg_in[32*i +: 32];
            end else begin
                shadow_d[i] = shadow_q[i];
            end
        end
    end

    // Shadow bank storage. A snap on the SEL edge is invisible to that read
    // because SEL samples shadow_q, the pre-snap contents.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                shadow_q[i] <= 32'h0000_0000;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    // Read source is the shadow bank.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            src_s[i] = shadow_q[i];
        end
    end
`else
    logic snap_unused_s;
    assign snap_unused_s = snap;

    // Read source is the live register bank.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            src_s[i] = reg_in[32*i +: 32];
        end
    end
`endif

    assign addr_ext_s = 32'(addr_q);

    // Register select: AND-OR mux over the bank so an out-of-range index
    // never indexes past the array and naturally yields zero.
    always_comb begin
        sel_data_s = 32'h0000_0000;
        sel_hit_s  = (addr_ext_s < NREGS_U);
        for (int i = 0; i < NREGS; i++) begin
            sel_data_s = sel_data_s | (src_s[i] & {32{addr_ext_s == 32'(i)}});
        end
    end

    // FSM next-state and output computation.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rd_data_d  = rd_data_q;
        rd_err_d   = rd_err_q;
        rd_valid_d = rd_valid_q;
        rd_busy_d  = rd_busy_q;
        case (state_q)
            ST_IDLE: begin
                if (rd_req) begin
                    state_d   = ST_SEL;
                    addr_d    = rd_addr;
                    rd_busy_d = 1'b1;
                end else begin
                    state_d   = ST_IDLE;
                    rd_busy_d = 1'b0;
                end
            end
            ST_SEL: begin
                state_d    = ST_RESP;
                rd_data_d  = sel_hit_s ? sel_data_s : 32'h0000_0000;
                rd_err_d   = ~sel_hit_s;
                rd_valid_d = 1'b1;
                rd_busy_d  = 1'b1;
            end
            ST_RESP: begin
                if (rd_ack) begin
                    state_d    = ST_IDLE;
                    rd_valid_d = 1'b0;
                    rd_busy_d  = 1'b0;
                end else begin
                    state_d    = ST_RESP;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                rd_valid_d = 1'b0;
                rd_busy_d  = 1'b0;
            end
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= {AW{1'b0}};
            rd_data_q  <= 32'h0000_0000;
            rd_err_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_busy_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rd_data_q  <= rd_data_d;
            rd_err_q   <= rd_err_d;
            rd_valid_q <= rd_valid_d;
            rd_busy_q  <= rd_busy_d;
        end
    end

    assign rd_busy  = rd_busy_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign rd_err   = rd_err_q;

endmodule

// File: tb/tb_reg32_readback.sv
module tb_reg32_readback;

    localparam int NREGS = 8;
    localparam int AW    = 4;

    logic                clk;
    logic                reset_n;
    logic [32*NREGS-1:0] reg_in;
    logic                snap;
    logic                rd_req;
    logic [AW-1:0]       rd_addr;
    logic                rd_ack;
    logic                rd_busy;
    logic                rd_valid;
    logic [31:0]         rd_data;
    logic                rd_err;

    reg32_readback #(.NREGS(NREGS), .AW(AW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .reg_in   (reg_in),
        .snap     (snap),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_ack   (rd_ack),
        .rd_busy  (rd_busy),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_err   (rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic          err;
        int            ack_wait;
    } vec_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   valid_rises = 0;
    logic prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every rising rd_valid pops one expected response.
    always @(negedge clk) begin
        if (rd_valid && !prev_valid) begin
            valid_rises++;
            if (sb_q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_data", rd_data, e.data);
                check("sb_err", {31'd0, rd_err}, {31'd0, e.err});
            end
        end
        prev_valid = rd_valid;
    end

    task automatic set_reg(input int idx, input logic [31:0] v);
        reg_in[32*idx +: 32] = v;
    endtask

    task automatic pulse_snap();
        @(posedge clk); #1;
        snap = 1'b1;
        @(posedge clk); #1;
        snap = 1'b0;
    endtask

    // One complete read with the given number of extra RESP cycles before ack.
    task automatic read_one(input logic [AW-1:0] a, input logic [31:0] d,
                            input logic e, input int ack_wait);
        exp_t x;
        @(posedge clk); #1;
        rd_req  = 1'b1;
        rd_addr = a;
        x.data = d;
        x.err  = e;
        sb_q.push_back(x);
        @(posedge clk); #1;               // edge k: accepted
        rd_req = 1'b0;
        check("busy_after_accept", {31'd0, rd_busy}, 32'd1);
        check("valid_after_accept", {31'd0, rd_valid}, 32'd0);
        @(posedge clk); #1;               // edge k+1: SEL -> RESP
        check("valid_in_resp", {31'd0, rd_valid}, 32'd1);
        for (int i = 0; i < ack_wait; i++) begin
            @(posedge clk); #1;
            check("valid_hold", {31'd0, rd_valid}, 32'd1);
            check("data_hold", rd_data, d);
        end
        rd_ack = 1'b1;
        @(posedge clk); #1;               // ack edge
        rd_ack = 1'b0;
        check("valid_after_ack", {31'd0, rd_valid}, 32'd0);
        check("busy_after_ack", {31'd0, rd_busy}, 32'd0);
        check("data_kept_after_ack", rd_data, d);
    endtask

    vec_t vecs[10];
    logic [31:0] snap_exp;

    initial begin
        reset_n = 1'b0;
        snap    = 1'b0;
        rd_req  = 1'b0;
        rd_ack  = 1'b0;
        rd_addr = '0;
        for (int i = 0; i < NREGS; i++) set_reg(i, 32'hCAFE_0000 + 32'(i));

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, rd_busy}, 32'd0);
        check("rst_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_data", rd_data, 32'd0);
        check("rst_err", {31'd0, rd_err}, 32'd0);
        reset_n = 1'b1;
        pulse_snap();

        // Table-driven reads, including out-of-range indices
        vecs[0] = '{4'd3,  32'hCAFE_0003, 1'b0, 0};
        vecs[1] = '{4'd0,  32'hCAFE_0000, 1'b0, 1};
        vecs[2] = '{4'd7,  32'hCAFE_0007, 1'b0, 2};
        vecs[3] = '{4'd12, 32'h0000_0000, 1'b1, 0};
        vecs[4] = '{4'd0,  32'hCAFE_0000, 1'b0, 0};
        vecs[5] = '{4'd8,  32'h0000_0000, 1'b1, 1};
        vecs[6] = '{4'd15, 32'h0000_0000, 1'b1, 0};
        vecs[7] = '{4'd5,  32'hCAFE_0005, 1'b0, 3};
        vecs[8] = '{4'd1,  32'hCAFE_0001, 1'b0, 0};
        vecs[9] = '{4'd6,  32'hCAFE_0006, 1'b0, 0};
        for (int v = 0; v < 10; v++) begin
            read_one(vecs[v].addr, vecs[v].data, vecs[v].err, vecs[v].ack_wait);
        end

        // Hold: data stable while source changes; requests in RESP and on the
        // accepting ack edge are dropped.
        begin
            exp_t x;
            @(posedge clk); #1;
            rd_req = 1'b1; rd_addr = 4'd3;
            x.data = 32'hCAFE_0003; x.err = 1'b0;
            sb_q.push_back(x);
            @(posedge clk); #1;
            rd_req = 1'b0;
            @(posedge clk); #1;
            set_reg(3, 32'h1234_5678);
            rd_req = 1'b1; rd_addr = 4'd1;
            for (int i = 0; i < 5; i++) begin
                @(posedge clk); #1;
                check("hold_valid", {31'd0, rd_valid}, 32'd1);
                check("hold_data", rd_data, 32'hCAFE_0003);
            end
            rd_ack = 1'b1;
            @(posedge clk); #1;
            rd_ack = 1'b0;
            rd_req = 1'b0;
            check("hold_ack_busy", {31'd0, rd_busy}, 32'd0);
            repeat (4) begin
                @(posedge clk); #1;
                check("dropped_req_busy", {31'd0, rd_busy}, 32'd0);
                check("dropped_req_valid", {31'd0, rd_valid}, 32'd0);
            end
            set_reg(3, 32'hCAFE_0003);
        end

        // Back-to-back reads with ack tied high: one valid pulse per 3 cycles
        begin
            int rises0;
            exp_t x;
            rises0 = valid_rises;
            for (int i = 0; i < NREGS; i++) begin
                x.data = 32'hCAFE_0000 + 32'(i); x.err = 1'b0;
                sb_q.push_back(x);
            end
            rd_ack = 1'b1;
            rd_req = 1'b1;
            for (int i = 0; i < NREGS; i++) begin
                rd_addr = 4'(i);
                @(posedge clk); #1;
                check("b2b_busy", {31'd0, rd_busy}, 32'd1);
                @(posedge clk); #1;
                check("b2b_valid", {31'd0, rd_valid}, 32'd1);
                check("b2b_data", rd_data, 32'hCAFE_0000 + 32'(i));
                if (i == NREGS - 1) rd_req = 1'b0;
                @(posedge clk); #1;
                check("b2b_valid_low", {31'd0, rd_valid}, 32'd0);
            end
            rd_ack = 1'b0;
            rd_req = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            check("b2b_pulses", 32'(valid_rises - rises0), 32'(NREGS));
        end

        // Reset mid-read in RESP
        begin
            exp_t x;
            @(posedge clk); #1;
            rd_req = 1'b1; rd_addr = 4'd2;
            x.data = 32'hCAFE_0002; x.err = 1'b0;
            sb_q.push_back(x);
            @(posedge clk); #1;
            rd_req = 1'b0;
            @(posedge clk); #1;
            check("pre_rst_valid", {31'd0, rd_valid}, 32'd1);
            @(posedge clk); #3;
            reset_n = 1'b0;
            #1;
            check("mid_rst_valid", {31'd0, rd_valid}, 32'd0);
            check("mid_rst_busy", {31'd0, rd_busy}, 32'd0);
            check("mid_rst_data", rd_data, 32'd0);
            check("mid_rst_err", {31'd0, rd_err}, 32'd0);
            @(posedge clk); #1;
            reset_n = 1'b1;
            repeat (5) begin
                @(posedge clk); #1;
                check("post_rst_valid", {31'd0, rd_valid}, 32'd0);
            end
        end

        // Snapshot behaviour
        set_reg(5, 32'hAAAA_0005);
        pulse_snap();
        set_reg(5, 32'h5555_0005);
`ifdef READBACK_SNAPSHOT_EN
        snap_exp = 32'hAAAA_0005;
`else
        snap_exp = 32'h5555_0005;
`endif
        read_one(4'd5, snap_exp, 1'b0, 0);

        repeat (2) @(posedge clk);
        #1;
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reg32_readback.md
# reg32_readback

Read-side companion to the 32-bit control registers. Takes the flattened outputs of a bank of NREGS 32-bit registers and returns one of them per request over a request/valid/acknowledge handshake, so slow control can read back configured values. It sits between the register bank and the command decoder. It adds no write path.

## Interface
- NREGS, 8: number of 32-bit registers in the bank (1..256).
- AW, 3: read address width; 2**AW >= NREGS.
- clk  input  1  single clock; all state is updated on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- reg_in  input  32*NREGS  flattened register values; register i occupies bits [32*i+31:32*i].
- snap  input  1  snapshot strobe; only used with READBACK_SNAPSHOT_EN.
- rd_req  input  1  read request; sampled only while rd_busy=0.
- rd_addr  input  AW  register index; sampled with rd_req.
- rd_ack  input  1  consumer has taken rd_data; sampled only in state RESP.
- rd_busy  output  1  a read is in flight; new requests are ignored.
- rd_valid  output  1  rd_data and rd_err are valid.
- rd_data  output  32  register value returned by the read.
- rd_err  output  1  rd_addr was >= NREGS.

## Operation
- Three-state FSM:
  - IDLE: rd_busy=0. On rd_req=1, latch rd_addr and go to SEL.
  - SEL: load rd_data from the selected register and go to RESP.
    - In-range address: rd_data = register[addr], rd_err=0.
    - rd_addr >= NREGS: rd_data = 32'h0000_0000, rd_err=1.
  - RESP: rd_valid=1; rd_data and rd_err are held stable. On rd_ack=1, go to IDLE.
- rd_busy=1 in SEL and RESP. rd_req while busy is dropped, not queued.
- rd_ack outside RESP has no effect.
- Only one read is outstanding at a time.
- The value returned is the source value present at the SEL edge. Later changes to the source do not alter rd_data during RESP.
- Reset values: state IDLE, rd_busy=0, rd_valid=0, rd_data=0, rd_err=0, latched address 0, shadow bank all 0.
- Reset asserted mid-read aborts the read. No rd_valid is produced for it after reset releases.

## Timing
- Request accepted at edge k: rd_busy=1 after edge k. rd_valid=1 and rd_data valid after edge k+1. Minimum latency is 2 cycles.
- rd_ack=1 at edge m in RESP: rd_valid=0 and rd_busy=0 after edge m.
- rd_ack tied high gives a 3-cycle read period. The earliest next acceptance is edge m+1.
- rd_req at edge m (the same edge as the accepting rd_ack) is ignored, because rd_busy is still 1 before that edge.
- rd_data keeps its last value after rd_valid falls, until the next SEL.

## Configuration
- READBACK_SNAPSHOT_EN defined:
  - An NREGS x 32 shadow bank loads all of reg_in on any edge with snap=1, in any FSM state.
  - Reads select from the shadow bank, so multi-register reads are coherent.
  - When snap coincides with a SEL edge, that read returns the pre-snap shadow value.
- READBACK_SNAPSHOT_EN not defined:
  - No shadow bank. SEL selects directly from reg_in.
  - snap is present but unused.

## Test plan
- Reset, then NREGS=8, reg3=32'hCAFE_0003, rd_req with addr 3 at edge k, rd_ack=1 from k+2 -> rd_valid rises after k+1 with rd_data=32'hCAFE_0003 and rd_err=0; rd_valid and rd_busy fall after k+2.
- Same read with rd_ack held 0 for 5 cycles while reg3 changes to 32'h1234_5678 -> rd_data stays 32'hCAFE_0003 until ack; second rd_req during RESP is ignored.
- AW=4, NREGS=8, read addr 12 -> rd_data=32'h0, rd_err=1; next read of addr 0 -> rd_err=0.
- Back-to-back reads of addr 0..7 with rd_ack tied 1 -> one rd_valid pulse every 3 cycles, data matches each register in order.
- reset_n pulsed low while in RESP -> rd_valid, rd_busy, rd_data, rd_err all 0 immediately; no rd_valid after release until a new request.
- With READBACK_SNAPSHOT_EN: snap with reg5=32'hAAAA_0005, then change reg5 to 32'h5555_0005, read addr 5 -> returns 32'hAAAA_0005; without the macro -> returns 32'h5555_0005.
